tq_perm_ctrl: RTL and testbench

TQ_PERM_CTRL -- requirements
Module: tq_perm_ctrl

---
 rtl/tq_perm_ctrl_pkg.sv | 48 ++++
 rtl/tq_perm_ctrl_valid_dly.sv | 34 +++
 rtl/tq_perm_ctrl.sv | 141 ++++++++++++++
 tb/tb_tq_perm_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tq_perm_ctrl_pkg.sv
// Shared definitions for the transform permutation controller: size codes,
// controller state encoding and the rows-per-block helpers.
package tq_perm_ctrl_pkg;

  // Block size codes as presented on i_size.
  typedef enum logic [1:0] {
    SIZE_4X4   = 2'd0,
    SIZE_8X8   = 2'd1,
    SIZE_16X16 = 2'd2,
    SIZE_32X32 = 2'd3
  } size_e;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Width of the drain down-counter; large enough to hold the maximum LAT of 8.
  localparam int DRAIN_W = 4;
  localparam int ROW_W   = 5;

  // Number of rows in a block of the given size (4, 8, 16 or 32).
  function automatic logic [5:0] rows_per_size(input size_e s);
    return 6'd4 << s;
  endfunction

  // Index of the final row of a block; the row counter stops here.
  function automatic logic [ROW_W-1:0] last_row_idx(input size_e s);
    logic [5:0] n;
    n = rows_per_size(s) - 6'd1;
    return n[ROW_W-1:0];
  endfunction

  // Permutation stage enables {en32, en16, en8}; each larger stage implies the smaller ones.
  function automatic logic [2:0] stage_enables(input size_e s);
    logic [2:0] en;
    case (s)
      SIZE_32X32: en = 3'b111;
      SIZE_16X16: en = 3'b011;
      SIZE_8X8:   en = 3'b001;
      default:    en = 3'b000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/tq_perm_ctrl_valid_dly.sv
// LAT-deep valid shift register that mirrors the downstream datapath latency.
module tq_valid_dly #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vld,
  output logic o_vld
);

  logic [LAT-1:0] sr_q;
  logic [LAT-1:0] sr_d;

  // Shift the acceptance strobe one stage per cycle.
  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = i_vld;
    for (int i = 1; i < LAT; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // Stage registers; reset drops any in-flight strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign o_vld = sr_q[LAT-1];

endmodule

// File: rtl/tq_perm_ctrl.sv
// Row sequencing controller for the transform permutation stages: latches the
// block configuration, counts accepted rows, drives the stage enables and
// tracks results through the datapath latency to signal block completion.
// LAT must lie in 1..8.
module tq_perm_ctrl
  import tq_perm_ctrl_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [1:0] i_size,
  input  logic       i_inverse,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_en8,
  output logic       o_en16,
  output logic       o_en32,
  output logic       o_inverse,
  output logic [4:0] o_row,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_done
);

  state_e             state_q, state_d;
  size_e              size_q, size_d;
  logic               inv_q, inv_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;

  logic accept;
  logic is_last_row;
  logic res_vld;
  logic drain_end;
  logic [2:0] en_vec;

  assign accept      = (state_q == ST_RUN) && i_valid;
  assign is_last_row = (row_q == last_row_idx(size_q));
  assign drain_end   = (state_q == ST_DRAIN) && (drain_q <= DRAIN_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start, last-row acceptance and drain expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_start)               state_d = ST_RUN;
      ST_RUN:   if (accept && is_last_row) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_end)             state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // Configuration latch, row counter and drain counter updates.
  always_comb begin
    size_d  = size_q;
    inv_d   = inv_q;
    row_d   = row_q;
    drain_d = drain_q;
    if ((state_q == ST_IDLE) && i_start) begin
      size_d = size_e'(i_size);
      inv_d  = i_inverse;
      row_d  = '0;
    end
    if (accept) begin
      if (is_last_row) begin
        // Counter parks on the last row; drain covers the datapath latency.
        drain_d = DRAIN_W'(LAT);
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end
    if ((state_q == ST_DRAIN) && (drain_q != '0)) begin
      drain_d = drain_q - DRAIN_W'(1);
    end
  end

  // Configuration and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q  <= SIZE_4X4;
      inv_q   <= 1'b0;
      row_q   <= '0;
      drain_q <= '0;
    end else begin
      size_q  <= size_d;
      inv_q   <= inv_d;
      row_q   <= row_d;
      drain_q <= drain_d;
    end
  end

  tq_valid_dly #(
    .LAT (LAT)
  ) u_valid_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (accept),
    .o_vld (res_vld)
  );

  assign en_vec = stage_enables(size_q);

  // Outputs decoded from state and latched configuration.
  always_comb begin
    o_ready   = 1'b0;
    o_busy    = 1'b0;
    o_en8     = 1'b0;
    o_en16    = 1'b0;
    o_en32    = 1'b0;
    o_inverse = 1'b0;
    o_done    = 1'b0;
    if (state_q != ST_IDLE) begin
      o_busy    = 1'b1;
      o_en8     = en_vec[0];
      o_en16    = en_vec[1];
      o_en32    = en_vec[2];
      o_inverse = inv_q;
    end
    if (state_q == ST_RUN) begin
      o_ready = 1'b1;
    end
    // The last result leaves the datapath in the final drain cycle.
    if (drain_end && res_vld) begin
      o_done = 1'b1;
    end
  end

  assign o_row   = row_q;
  assign o_valid = res_vld;

endmodule

// File: tb/tb_tq_perm_ctrl.sv
// Randomised bench for tq_perm_ctrl with a cycle-numbered behavioural model.
module tb_tq_perm_ctrl;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
  logic [1:0] i_size;
  logic       i_inverse;
  logic       i_valid;
  logic       o_ready, o_en8, o_en16, o_en32, o_inverse;
  logic [4:0] o_row;
  logic       o_valid, o_busy, o_done;

  tq_perm_ctrl #(.LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_size(i_size),
    .i_inverse(i_inverse), .i_valid(i_valid), .o_ready(o_ready),
    .o_en8(o_en8), .o_en16(o_en16), .o_en32(o_en32), .o_inverse(o_inverse),
    .o_row(o_row), .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: block bookkeeping in terms of rows and cycle numbers.
  int cyc = 0;
  bit m_active = 0;
  int m_size = 0, m_inv = 0, m_rows = 0, m_acc = 0, m_rcnt = 0, m_done_cyc = -1;
  int vq[$];

  // Observations taken from the DUT for the literal block-level checks.
  int n_valid = 0, n_done = 0, obs_acc_cyc = 0, obs_done_cyc = 0;
  int last_cfg = 0;

  // Per-cycle compare against the model, then advance the model past the edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", o_ready, 0);   chk("rst_busy", o_busy, 0);
      chk("rst_valid", o_valid, 0);   chk("rst_done", o_done, 0);
      chk("rst_en", {o_en32, o_en16, o_en8}, 0);
      chk("rst_inv", o_inverse, 0);   chk("rst_row", o_row, 0);
      m_active = 0; m_size = 0; m_inv = 0; m_acc = 0; m_rows = 0;
      m_rcnt = 0; m_done_cyc = -1;
      vq.delete();
    end else begin
      bit e_ready, e_valid, e_done;
      e_ready = m_active && (m_acc < m_rows);
      e_valid = (vq.size() > 0) && (vq[0] == cyc);
      e_done  = m_active && (m_acc == m_rows) && (m_done_cyc == cyc);
      chk("ready", o_ready, int'(e_ready));
      chk("busy", o_busy, int'(m_active));
      chk("valid", o_valid, int'(e_valid));
      chk("done", o_done, int'(e_done));
      chk("en32", o_en32, int'(m_active && m_size == 3));
      chk("en16", o_en16, int'(m_active && m_size >= 2));
      chk("en8", o_en8, int'(m_active && m_size >= 1));
      chk("inverse", o_inverse, m_active ? m_inv : 0);
      chk("row", o_row, m_rcnt);

      if (o_valid) n_valid++;
      if (o_done) begin n_done++; obs_done_cyc = cyc; end
      if (o_ready && i_valid) begin
        obs_acc_cyc = cyc;
        last_cfg = {o_en32, o_en16, o_en8, o_inverse};
      end

      if (e_valid) void'(vq.pop_front());
      if (!m_active) begin
        if (i_start) begin
          m_active = 1; m_size = int'(i_size); m_inv = int'(i_inverse);
          m_rows = 4 << m_size; m_acc = 0; m_rcnt = 0; m_done_cyc = -1;
        end
      end else begin
        if (e_ready && i_valid) begin
          vq.push_back(cyc + LAT);
          if (m_acc == m_rows - 1) m_done_cyc = cyc + LAT;
          else m_rcnt++;
          m_acc++;
        end
        if (e_done) m_active = 0;
      end
    end
    cyc++;
  end

  // Runs one block starting in the current cycle (called at posedge+1).
  // mode: 0 continuous valid, 1 alternate valid, 2 random valid + random stray starts.
  task automatic run_block(input int size, input int inv, input int mode,
                           input int stray_at, input int abort_at);
    int d0;
    int k;
    d0 = n_done;
    i_start = 1; i_size = 2'(size); i_inverse = inv[0];
    i_valid = (mode == 0);
    @(posedge clk); #1;
    for (k = 0; k < 300; k++) begin
      if (n_done != d0) break;
      if (abort_at >= 0 && m_acc == abort_at) begin
        i_start = 0; i_valid = 1; rst_n = 0;
        @(posedge clk); @(posedge clk); #3; rst_n = 1;
        @(posedge clk); #1;
        break;
      end
      i_start = 0;
      if (mode == 0) i_valid = 1;
      else if (mode == 1) i_valid = k[0];
      else i_valid = 1'($urandom_range(0, 1));
      if (stray_at >= 0 && m_acc == stray_at) begin
        i_start = 1; i_size = 2'd0; i_inverse = ~inv[0];
      end
      if (mode == 2 && $urandom_range(0, 7) == 0) begin
        i_start = 1; i_size = 2'($urandom); i_inverse = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    if (k == 300) chk("block_timeout", k, -1);
    i_start = 0;
    i_valid = 1;
  endtask

  initial begin
    int v0, d0;
    rst_n = 0; i_start = 0; i_size = 0; i_inverse = 0; i_valid = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
    i_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ready", o_ready, 0);
    chk("idle_row", o_row, 0);

    // 16x16 inverse, continuous valid.
    v0 = n_valid; d0 = n_done;
    run_block(2, 1, 0, -1, -1);
    $display("block size=2 inv=1 valids=%0d dones=%0d", n_valid - v0, n_done - d0);
    chk("b1_valids", n_valid - v0, 16);
    chk("b1_dones", n_done - d0, 1);
    chk("b1_done_lat", obs_done_cyc - obs_acc_cyc, 2);
    chk("b1_cfg", last_cfg, 4'b0111);

    // 4x4 with bubbles; started the cycle after the previous o_done.
    v0 = n_valid; d0 = n_done;
    run_block(0, 0, 1, -1, -1);
    $display("block size=0 inv=0 valids=%0d dones=%0d", n_valid - v0, n_done - d0);
    chk("b2_valids", n_valid - v0, 4);
    chk("b2_dones", n_done - d0, 1);
    chk("b2_cfg", last_cfg, 4'b0000);

    // 32x32 forward with a stray start at row 10.
    v0 = n_valid; d0 = n_done;
    run_block(3, 0, 0, 10, -1);
    $display("block size=3 inv=0 valids=%0d dones=%0d", n_valid - v0, n_done - d0);
    chk("b3_valids", n_valid - v0, 32);
    chk("b3_cfg", last_cfg, 4'b1110);

    // 8x8 aborted by reset while row 5 is presented.
    repeat (2) @(posedge clk);
    #1;
    v0 = n_valid; d0 = n_done;
    run_block(1, 1, 0, -1, 5);
    repeat (6) @(posedge clk);
    #1;
    $display("block size=1 aborted valids=%0d dones=%0d", n_valid - v0, n_done - d0);
    chk("b4_valids", n_valid - v0, 3);
    chk("b4_dones", n_done - d0, 0);

    // Fresh block after reset.
    v0 = n_valid; d0 = n_done;
    run_block(1, 0, 0, -1, -1);
    $display("block size=1 inv=0 valids=%0d dones=%0d", n_valid - v0, n_done - d0);
    chk("b5_valids", n_valid - v0, 8);
    chk("b5_dones", n_done - d0, 1);

    // Random blocks with random gaps, bubbles and stray starts.
    for (int b = 0; b < 8; b++) begin
      int sz;
      sz = int'($urandom_range(0, 3));
      v0 = n_valid;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_block(sz, int'($urandom_range(0, 1)), 2, -1, -1);
      $display("block size=%0d random valids=%0d", sz, n_valid - v0);
      chk("rnd_valids", n_valid - v0, 4 << sz);
    end

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
